// File: rtl/hockey_input_cond.sv
`default_nettype none
// ============================================================================
// Module  : hockey_input_cond
// Purpose : Synchronises and debounces both player buttons, emits one-cycle
//           press pulses and captures direction / clamped Y on each press.
// Revision: 1.0  initial release
// ============================================================================
module hockey_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int Y_MAX           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNA_RAW,
    input  logic       BTNB_RAW,
    input  logic [1:0] DIRA_RAW,
    input  logic [1:0] DIRB_RAW,
    input  logic [2:0] YA_RAW,
    input  logic [2:0] YB_RAW,
    output logic       BTNA,
    output logic       BTNB,
    output logic [1:0] DIRA,
    output logic [1:0] DIRB,
    output logic [2:0] YA,
    output logic [2:0] YB
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       c_y_max    = 3'(Y_MAX);

    // Index 0 is player A, index 1 is player B.
    logic [1:0]      w_btn_raw;
    logic [1:0][1:0] w_dir_raw;
    logic [1:0][2:0] w_y_raw;
    logic [1:0]      w_btn;
    logic [1:0][1:0] w_dir;
    logic [1:0][2:0] w_y;

    assign w_btn_raw = {BTNB_RAW, BTNA_RAW};
    assign w_dir_raw = {DIRB_RAW, DIRA_RAW};
    assign w_y_raw   = {YB_RAW, YA_RAW};

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic             r_btn_s1;
        logic             r_btn_s2;
        logic [1:0]       r_dir_s1;
        logic [1:0]       r_dir_s2;
        logic [2:0]       r_y_s1;
        logic [2:0]       r_y_s2;
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pulse;
        logic [1:0]       r_dir_cap;
        logic [2:0]       r_y_cap;
        logic             w_flip;
        logic             w_press;
        logic [2:0]       w_y_clamped;

        // The synchronised level has disagreed with db for DEBOUNCE_CYCLES edges.
        assign w_flip      = (r_btn_s2 != r_db) && (r_cnt == c_cnt_last);
        assign w_press     = w_flip && r_btn_s2;
        assign w_y_clamped = (r_y_s2 > c_y_max) ? c_y_max : r_y_s2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_btn_s1  <= 1'b0;
                r_btn_s2  <= 1'b0;
                r_dir_s1  <= '0;
                r_dir_s2  <= '0;
                r_y_s1    <= '0;
                r_y_s2    <= '0;
                r_db      <= 1'b0;
                r_cnt     <= '0;
                r_pulse   <= 1'b0;
                r_dir_cap <= '0;
                r_y_cap   <= '0;
            end else begin
                r_btn_s1 <= w_btn_raw[p];
                r_btn_s2 <= r_btn_s1;
                r_dir_s1 <= w_dir_raw[p];
                r_dir_s2 <= r_dir_s1;
                r_y_s1   <= w_y_raw[p];
                r_y_s2   <= r_y_s1;

                if (r_btn_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_db  <= r_btn_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end

                r_pulse <= w_press;
                if (w_press) begin
                    r_dir_cap <= r_dir_s2;
                    r_y_cap   <= w_y_clamped;
                end
            end
        end

        assign w_btn[p] = r_pulse;
        assign w_dir[p] = r_dir_cap;
        assign w_y[p]   = r_y_cap;
    end

    assign BTNA = w_btn[0];
    assign BTNB = w_btn[1];
    assign DIRA = w_dir[0];
    assign DIRB = w_dir[1];
    assign YA   = w_y[0];
    assign YB   = w_y[1];

endmodule
`default_nettype wire

// File: tb/tb_hockey_input_cond.sv
`default_nettype none
// ============================================================================
// Module  : tb_hockey_input_cond
// Purpose : Self-checking bench: directed vector table, hand-written corner
//           sequences and randomised traffic against a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
module tb_hockey_input_cond;

    localparam int c_deb   = 4;
    localparam int c_y_max = 4;

    logic       clk;
    logic       rst;
    logic       btna_raw, btnb_raw;
    logic [1:0] dira_raw, dirb_raw;
    logic [2:0] ya_raw, yb_raw;
    logic       btna, btnb;
    logic [1:0] dira, dirb;
    logic [2:0] ya, yb;

    hockey_input_cond #(
        .DEBOUNCE_CYCLES(c_deb),
        .CNT_W          (3),
        .Y_MAX          (c_y_max)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .BTNA_RAW(btna_raw),
        .BTNB_RAW(btnb_raw),
        .DIRA_RAW(dira_raw),
        .DIRB_RAW(dirb_raw),
        .YA_RAW  (ya_raw),
        .YB_RAW  (yb_raw),
        .BTNA    (btna),
        .BTNB    (btnb),
        .DIRA    (dira),
        .DIRB    (dirb),
        .YA      (ya),
        .YB      (yb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Packed layout used everywhere: {btn_a, dir_a, y_a, btn_b, dir_b, y_b}
    logic [11:0] dut_out;
    assign dut_out = {btna, dira, ya, btnb, dirb, yb};

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [11:0] raw_q[$];   // raw samples still in flight through the synchroniser
    logic [11:0] sync_hist[$]; // last c_deb synchronised samples
    logic        m_db [2];
    logic        e_btn[2];
    logic [1:0]  e_dir[2];
    logic [2:0]  e_y  [2];

    function automatic logic [5:0] fld(input logic [11:0] v, input int p);
        return (p == 0) ? v[11:6] : v[5:0];
    endfunction

    function automatic logic [11:0] exp_vec();
        return {e_btn[0], e_dir[0], e_y[0], e_btn[1], e_dir[1], e_y[1]};
    endfunction

    task automatic model_reset();
        raw_q = '{12'd0, 12'd0};
        sync_hist.delete();
        for (int p = 0; p < 2; p++) begin
            m_db[p] = 1'b0; e_btn[p] = 1'b0; e_dir[p] = '0; e_y[p] = '0;
        end
    endtask

    task automatic model_edge();
        logic [11:0] s;
        logic [5:0]  f;
        bit          stable;
        if (rst) begin
            model_reset();
            return;
        end
        raw_q.push_back({btna_raw, dira_raw, ya_raw, btnb_raw, dirb_raw, yb_raw});
        s = raw_q.pop_front();
        sync_hist.push_back(s);
        if (sync_hist.size() > c_deb) void'(sync_hist.pop_front());
        for (int p = 0; p < 2; p++) begin
            f = fld(s, p);
            e_btn[p] = 1'b0;
            // Level changes once the last c_deb synchronised samples all differ from it.
            stable = (sync_hist.size() == c_deb);
            foreach (sync_hist[i]) if (fld(sync_hist[i], p) >> 5 == 6'(m_db[p])) stable = 0;
            if (stable) begin
                m_db[p] = f[5];
                if (f[5]) begin
                    e_btn[p] = 1'b1;
                    e_dir[p] = f[4:3];
                    e_y[p]   = (int'(f[2:0]) > c_y_max) ? 3'(c_y_max) : f[2:0];
                end
            end
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [11:0] v);
        {btna_raw, dira_raw, ya_raw, btnb_raw, dirb_raw, yb_raw} = v;
    endtask

    // Asserts rst away from the clock edge and checks the outputs clear at once.
    task automatic async_reset(input string name, input int edges);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check(name, dut_out, 12'h000);
        for (int i = 0; i < edges; i++) begin
            edge_step();
            check({name, "_hold"}, dut_out, 12'h000);
        end
        #2;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [11:0] in;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic ba, input logic bb,
                                input logic [1:0] da, input logic [1:0] db_in,
                                input logic [2:0] ya_in, input logic [2:0] yb_in,
                                input logic eba, input logic ebb,
                                input logic [1:0] eda, input logic [1:0] edb,
                                input logic [2:0] eya, input logic [2:0] eyb);
        vec_t v;
        v.in  = {ba, da, ya_in, bb, db_in, yb_in};
        v.exp = {eba, eda, eya, ebb, edb, eyb};
        tbl.push_back(v);
    endfunction

    logic [12:0] bounce;
    logic [11:0] cur;

    initial begin
        rst = 1'b1;
        set_in(12'h000);
        model_reset();

        // Clean A press: pulse 5 edges after first sample, operands captured and held.
        repeat (3) add(0, 0, 2'd1, 2'd0, 3'd2, 3'd0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0);
        for (int i = 0; i < 10; i++)
            add(1, 0, 2'd1, 2'd0, 3'd2, 3'd0, i == 5, 0,
                (i >= 5) ? 2'd1 : 2'd0, 2'd0, (i >= 5) ? 3'd2 : 3'd0, 3'd0);
        repeat (6) add(0, 0, 2'd3, 2'd0, 3'd0, 3'd0, 0, 0, 2'd1, 2'd0, 3'd2, 3'd0);
        // Clamp: Y=7 captures as 4, DIR 3 forwarded; then Y=3 captures as 3.
        repeat (3) add(0, 0, 2'd3, 2'd3, 3'd0, 3'd7, 0, 0, 2'd1, 2'd0, 3'd2, 3'd0);
        for (int i = 0; i < 6; i++)
            add(0, 1, 2'd3, 2'd3, 3'd0, 3'd7, 0, i == 5, 2'd1,
                (i == 5) ? 2'd3 : 2'd0, 3'd2, (i == 5) ? 3'd4 : 3'd0);
        repeat (6) add(0, 0, 2'd3, 2'd3, 3'd0, 3'd3, 0, 0, 2'd1, 2'd3, 3'd2, 3'd4);
        for (int i = 0; i < 7; i++)
            add(0, 1, 2'd3, 2'd3, 3'd0, 3'd3, 0, i == 5, 2'd1, 2'd3, 3'd2,
                (i >= 5) ? 3'd3 : 3'd4);

        #12;
        check("reset_state", dut_out, 12'h000);
        edge_step();
        check("reset_state_edge", dut_out, 12'h000);
        #2;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].in);
            edge_step();
            check($sformatf("table[%0d]", i), dut_out, tbl[i].exp);
        end

        // Bounce on B: only the final stable run produces a pulse.
        btnb_raw = 1'b0;
        repeat (8) begin
            edge_step();
            check("b_release", {11'd0, btnb}, 12'd0);
        end
        bounce = 13'b1011011111111;
        for (int i = 0; i < 13; i++) begin
            btnb_raw = bounce[12 - i];
            edge_step();
            check("b_bounce", {11'd0, btnb}, {11'd0, i == 10});
        end
        btnb_raw = 1'b0;
        repeat (8) edge_step();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) begin
                btnb_raw = (i < 3);
                edge_step();
                check("b_glitch3", {11'd0, btnb}, 12'd0);
            end
        end

        // Simultaneous press and hold, then release and press again.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < ((r == 0) ? 20 : 8); i++) begin
                btna_raw = 1'b1; btnb_raw = 1'b1;
                edge_step();
                check("both_press", {10'd0, btna, btnb}, (i == 5) ? 12'd3 : 12'd0);
            end
            for (int i = 0; i < 6; i++) begin
                btna_raw = 1'b0; btnb_raw = 1'b0;
                edge_step();
                check("both_release", {10'd0, btna, btnb}, 12'd0);
            end
        end

        // Reset mid-debounce with the button held through reset release.
        btna_raw = 1'b1;
        edge_step();
        check("a_pre_rst", {11'd0, btna}, 12'd0);
        edge_step();
        check("a_pre_rst", {11'd0, btna}, 12'd0);
        async_reset("mid_rst", 2);
        for (int i = 0; i < 8; i++) begin
            edge_step();
            check("a_after_rst", {11'd0, btna}, {11'd0, i == 5});
        end

        // Randomised traffic against the model.
        cur = {btna_raw, dira_raw, ya_raw, btnb_raw, dirb_raw, yb_raw};
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) cur[11] = ~cur[11];
            if ($urandom_range(0, 5) == 0) cur[5]  = ~cur[5];
            if ($urandom_range(0, 9) == 0) cur[10:6] = 5'($urandom);
            if ($urandom_range(0, 9) == 0) cur[4:0]  = 5'($urandom);
            set_in(cur);
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst", $urandom_range(1, 3));
            edge_step();
            check("random", dut_out, exp_vec());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hockey_input_cond.md
Name: hockey_input_cond

Overview:
Upstream front-end for the hockey game core. It conditions the raw player controls before the core sees them: it synchronises and debounces the two player buttons, turns each press into a single-cycle pulse, and captures that player's direction and Y position on the press edge. Its outputs drive the core's BTNA, BTNB, DIRA, DIRB, YA and YB inputs directly, so the core only ever sees clean, one-cycle button events with stable operands.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive synchronised cycles at the new level before the debounced level changes (must be >= 1).
CNT_W, 3, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
Y_MAX, 4, largest legal Y coordinate; larger captured Y values are clamped to this.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
BTNA_RAW  in  1  player A button, asynchronous/bouncy
BTNB_RAW  in  1  player B button, asynchronous/bouncy
DIRA_RAW  in  2  player A direction
DIRB_RAW  in  2  player B direction
YA_RAW  in  3  player A Y position
YB_RAW  in  3  player B Y position
BTNA  out  1  one-cycle press pulse, player A
BTNB  out  1  one-cycle press pulse, player B
DIRA  out  2  direction captured at last A press
DIRB  out  2  direction captured at last B press
YA  out  3  clamped Y captured at last A press
YB  out  3  clamped Y captured at last B press

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous and active-high.
- Reset: all synchronisers, debounced levels, counters and outputs clear to 0, immediately on rst assertion. No pulse is produced while rst is high.
- Synchronisation: every raw input (buttons, DIR, Y) passes through a 2-flop synchroniser, reset value 0.
- Debounce (per button): debounced level db and counter cnt.
  - If sync2 == db: cnt <= 0.
  - If sync2 != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If sync2 != db and cnt == DEBOUNCE_CYCLES-1: db <= sync2 and cnt <= 0.
- Glitches: any excursion shorter than DEBOUNCE_CYCLES synchronised cycles resets cnt. It changes nothing and produces no pulse.
- Press pulse: at the same edge where db goes 0->1, BTNx <= 1. At every other edge, BTNx <= 0. The pulse is therefore exactly one cycle wide.
- Release: a 1->0 transition of db produces no pulse.
- Latency: if the raw button is first sampled high at edge k and stays high, BTNx is high from edge k+1+DEBOUNCE_CYCLES to edge k+2+DEBOUNCE_CYCLES. With the default of 4, the pulse appears at edge k+5.
- Capture: at the pulse edge, DIRx <= the synchronised DIR value and Yx <= min(synchronised Y, Y_MAX).
  - DIR is passed through unmodified; code 3 is forwarded as-is and the core decides what it means.
  - Captured values hold until the next press of the same player.
- Holding a button: no repeat pulses. A new pulse requires a debounced release followed by a debounced press.
- Simultaneous presses: players are fully independent, so both pulses may assert in the same cycle. Arbitration belongs to the core.
- Reset mid-count: cnt and db clear and any pending pulse is dropped.
- Button held through reset release: because db restarts at 0, one pulse is produced DEBOUNCE_CYCLES+2 edges after release.
- Operand timing: DIR/Y must be stable from at least 2 cycles before the button reaches the synchroniser until the pulse. Operands changing during that window give whichever value is in sync2 at the pulse edge.

Test Plan:
- Reset: assert rst mid-run with random inputs -> all six outputs read 0 asynchronously, before the next clk edge; no BTNA/BTNB pulse while rst is high.
- Clean A press: DIRA_RAW=1, YA_RAW=2, then BTNA_RAW=1 held 10 cycles -> BTNA high for exactly 1 cycle, 5 edges after BTNA_RAW is first sampled high; DIRA=1 and YA=2 from that edge onward and unchanged after release.
- Bounce on B: BTNB_RAW pattern 1,0,1,1,0 then 1 for 8 cycles -> exactly one BTNB pulse, timed from the start of the final stable run; no pulse for 3-cycle-high glitches.
- Clamp: YB_RAW=7, DIRB_RAW=3, press B -> YB=4, DIRB=3; then YB_RAW=3, press again -> YB=3.
- Simultaneous press and hold: both raw buttons rise on the same edge and are held 20 cycles -> BTNA and BTNB pulse in the same cycle, once each; no further pulses until each is released for >= 4 cycles and pressed again.
- Reset mid-debounce: press A, assert rst 2 cycles later while the button is still held, release rst -> no pulse before reset; exactly one pulse 6 edges after rst deasserts.
